// File: rtl/gsensor_spi_sequencer.sv
// ADXL345 SPI sequencer: three config writes after reset, then periodic
// 6-byte burst reads of DATAX0..DATAZ1 published as signed X/Y/Z samples.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_INIT0   | write BW_RATE (0x2C)
// S_INIT1   | write DATA_FORMAT (0x31)
// S_INIT2   | write POWER_CTL (0x2D)
// S_WAIT    | idle, waiting for enable and the sample period timer
// S_READ    | burst read frame in progress
// S_PUBLISH | post-read gap; samples were latched on the SS_n rise
module gsensor_spi_sequencer #(
   parameter int         CLK_DIV       = 5,
   parameter int         SAMPLE_PERIOD = 500000,
   parameter logic [7:0] BW_RATE_VAL   = 8'h0A,
   parameter logic [7:0] FORMAT_VAL    = 8'h08,
   parameter logic [7:0] POWER_VAL     = 8'h08
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic        enable,
   input  logic        gsensor_MISO,
   output logic        gsensor_MOSI,
   output logic        gsensor_SCLK,
   output logic        gsensor_SS_n,
   output logic [15:0] accel_x,
   output logic [15:0] accel_y,
   output logic [15:0] accel_z,
   output logic        accel_valid,
   output logic        init_done,
   output logic        busy,
   output logic [15:0] sample_count
);

   localparam int DW = $clog2(CLK_DIV + 1);
   localparam int GW = $clog2(2 * CLK_DIV + 1);
   localparam int PW = $clog2(SAMPLE_PERIOD + 1);
   localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(2 * CLK_DIV - 1);
   localparam logic [PW-1:0] PER_LOAD = PW'(SAMPLE_PERIOD - 1);

   typedef enum logic [2:0] {
      S_INIT0, S_INIT1, S_INIT2, S_WAIT, S_READ, S_PUBLISH
   } state_t;

   // Bit-level position inside a frame; PH_HOLD is the extra half-period
   // after the last rising edge, PH_GAP keeps SS_n high before the next frame.
   typedef enum logic [2:0] {
      PH_IDLE, PH_SETUP, PH_LOW, PH_HIGH, PH_HOLD, PH_GAP
   } phase_t;

   state_t          r_state;
   phase_t          r_phase;
   logic [DW-1:0]   r_div;
   logic [GW-1:0]   r_gap;
   logic [PW-1:0]   r_period;
   logic [5:0]      r_bits;
   logic [55:0]     r_tx;
   logic [47:0]     r_rx;
   logic            r_ss_n;
   logic            r_sclk;
   logic            r_mosi;
   logic [15:0]     r_ax;
   logic [15:0]     r_ay;
   logic [15:0]     r_az;
   logic            r_valid;
   logic            r_init_done;
   logic            r_busy;
   logic [15:0]     r_count;

   logic            w_free;
   logic            w_is_init;
   logic            w_rd_go;
   logic            w_start;
   logic [15:0]     w_cmd_word;

   // A new frame may begin from idle or on the last cycle of a gap, so
   // back-to-back frames are separated by exactly 2*CLK_DIV cycles.
   assign w_free    = (r_phase == PH_IDLE) || ((r_phase == PH_GAP) && (r_gap == '0));
   assign w_is_init = (r_state == S_INIT0) || (r_state == S_INIT1) || (r_state == S_INIT2);
   assign w_rd_go   = enable && (r_period == '0) &&
                      ((r_state == S_WAIT) || (r_state == S_PUBLISH));
   assign w_start   = w_free && (w_is_init || w_rd_go);

   // Register/value pair for the pending configuration write.
   always_comb begin
      w_cmd_word = 16'h0000;
      case (r_state)
         S_INIT0: w_cmd_word = {8'h2C, BW_RATE_VAL};
         S_INIT1: w_cmd_word = {8'h31, FORMAT_VAL};
         S_INIT2: w_cmd_word = {8'h2D, POWER_VAL};
         default: w_cmd_word = 16'h0000;
      endcase
   end

   // Sequencer FSM, SPI mode-3 bit engine and sample publishing.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state     <= S_INIT0;
         r_phase     <= PH_IDLE;
         r_div       <= '0;
         r_gap       <= '0;
         r_period    <= '0;
         r_bits      <= 6'd0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_ss_n      <= 1'b1;
         r_sclk      <= 1'b1;
         r_mosi      <= 1'b0;
         r_ax        <= 16'h0000;
         r_ay        <= 16'h0000;
         r_az        <= 16'h0000;
         r_valid     <= 1'b0;
         r_init_done <= 1'b0;
         r_busy      <= 1'b0;
         r_count     <= 16'h0000;
      end else begin
         r_valid <= 1'b0;
         if (r_period != '0)
            r_period <= r_period - PW'(1);

         if (w_start) begin
            r_ss_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_phase <= PH_SETUP;
            r_div   <= DIV_LOAD;
            if (w_is_init) begin
               r_tx   <= {w_cmd_word, 40'h0};
               r_bits <= 6'd16;
            end else begin
               r_tx     <= {8'hF2, 48'h0};
               r_bits   <= 6'd56;
               r_state  <= S_READ;
               r_period <= PER_LOAD;
            end
         end else begin
            unique case (r_phase)
               PH_IDLE: begin
               end
               PH_SETUP, PH_HIGH: begin
                  if (r_div != '0) begin
                     r_div <= r_div - DW'(1);
                  end else begin
                     r_div <= DIV_LOAD;
                     if ((r_phase == PH_HIGH) && (r_bits == 6'd0)) begin
                        r_phase <= PH_HOLD;
                     end else begin
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_tx[55];
                        r_tx    <= {r_tx[54:0], 1'b0};
                        r_phase <= PH_LOW;
                     end
                  end
               end
               PH_LOW: begin
                  if (r_div != '0) begin
                     r_div <= r_div - DW'(1);
                  end else begin
                     r_div   <= DIV_LOAD;
                     r_sclk  <= 1'b1;
                     r_rx    <= {r_rx[46:0], gsensor_MISO};
                     r_bits  <= r_bits - 6'd1;
                     r_phase <= PH_HIGH;
                  end
               end
               PH_HOLD: begin
                  if (r_div != '0) begin
                     r_div <= r_div - DW'(1);
                  end else begin
                     r_ss_n  <= 1'b1;
                     r_mosi  <= 1'b0;
                     r_phase <= PH_GAP;
                     r_gap   <= GAP_LOAD;
                     case (r_state)
                        S_INIT0: r_state <= S_INIT1;
                        S_INIT1: r_state <= S_INIT2;
                        S_INIT2: begin
                           r_state     <= S_WAIT;
                           r_init_done <= 1'b1;
                           r_period    <= PER_LOAD;
                        end
                        S_READ: begin
                           r_state <= S_PUBLISH;
                           r_ax    <= {r_rx[39:32], r_rx[47:40]};
                           r_ay    <= {r_rx[23:16], r_rx[31:24]};
                           r_az    <= {r_rx[7:0],   r_rx[15:8]};
                           r_valid <= 1'b1;
                           r_count <= r_count + 16'd1;
                        end
                        default: r_state <= S_WAIT;
                     endcase
                  end
               end
               PH_GAP: begin
                  if (r_gap != '0) begin
                     r_gap <= r_gap - GW'(1);
                  end else begin
                     r_phase <= PH_IDLE;
                     r_busy  <= 1'b0;
                     if (r_state == S_PUBLISH)
                        r_state <= S_WAIT;
                  end
               end
               default: r_phase <= PH_IDLE;
            endcase
         end
      end
   end

   assign gsensor_SS_n = r_ss_n;
   assign gsensor_SCLK = r_sclk;
   assign gsensor_MOSI = r_mosi;
   assign accel_x      = r_ax;
   assign accel_y      = r_ay;
   assign accel_z      = r_az;
   assign accel_valid  = r_valid;
   assign init_done    = r_init_done;
   assign busy         = r_busy;
   assign sample_count = r_count;

endmodule

// File: tb/tb_gsensor_spi_sequencer.sv
// Directed bench for gsensor_spi_sequencer with an SPI mode-3 slave model.
module tb_gsensor_spi_sequencer;

   localparam int CD = 2;
   localparam int SP = 2000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        miso = 1'b0;
   logic        mosi, sclk, ss_n, vld, idone, busy;
   logic [15:0] ax, ay, az, cnt;

   logic        en_f = 1'b1;
   logic        miso_f = 1'b0;
   logic        mosi_f, sclk_f, ss_f, vld_f, idone_f, busy_f;
   logic [15:0] ax_f, ay_f, az_f, cnt_f;

   always #5 clk = ~clk;

   gsensor_spi_sequencer #(.CLK_DIV(CD), .SAMPLE_PERIOD(SP)) u_dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .enable(en), .gsensor_MISO(miso),
      .gsensor_MOSI(mosi), .gsensor_SCLK(sclk), .gsensor_SS_n(ss_n),
      .accel_x(ax), .accel_y(ay), .accel_z(az), .accel_valid(vld),
      .init_done(idone), .busy(busy), .sample_count(cnt));

   gsensor_spi_sequencer #(.CLK_DIV(CD), .SAMPLE_PERIOD(100)) u_fast (
      .clk_clk(clk), .reset_reset_n(rst_n), .enable(en_f), .gsensor_MISO(miso_f),
      .gsensor_MOSI(mosi_f), .gsensor_SCLK(sclk_f), .gsensor_SS_n(ss_f),
      .accel_x(ax_f), .accel_y(ay_f), .accel_z(az_f), .accel_valid(vld_f),
      .init_done(idone_f), .busy(busy_f), .sample_count(cnt_f));

   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // frame log for the main DUT
   int          cyc = 0;
   int          n_fall = 0, n_rise = 0, vld_cycles = 0;
   int          fall_cyc [64];
   int          rise_cyc [64];
   int          f_bits   [64];
   int          f_len    [64];
   logic [55:0] f_word   [64];
   logic        f_idone  [64];
   logic        f_vld    [64];
   logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
   int          bitcnt = 0, last_edge = 0;
   logic [55:0] mosi_w = '0;
   logic [55:0] slv_tx = '0;
   logic [47:0] slv_data = 48'h0;

   // slave model and mode-3 protocol checks, sampled on the falling clk edge
   always @(negedge clk) begin
      cyc++;
      if (vld) vld_cycles++;
      if (ss_n) chk("sclk_idle_high", sclk, 1'b1);
      if (prev_ss && !ss_n) begin
         if (n_fall < 64) fall_cyc[n_fall] = cyc;
         n_fall++;
         bitcnt = 0;
         mosi_w = '0;
         slv_tx = {8'hA5, slv_data};
         last_edge = cyc;
      end
      if (!ss_n && prev_sclk && !sclk) begin
         chk("half_period_fall", cyc - last_edge, CD);
         last_edge = cyc;
         miso = slv_tx[55];
         slv_tx = {slv_tx[54:0], 1'b0};
      end
      if (!ss_n && !prev_sclk && sclk) begin
         chk("half_period_rise", cyc - last_edge, CD);
         chk("mosi_stable_at_rise", mosi, prev_mosi);
         last_edge = cyc;
         mosi_w = {mosi_w[54:0], mosi};
         bitcnt++;
      end
      if (!prev_ss && ss_n && n_rise < 64 && n_fall > 0) begin
         rise_cyc[n_rise] = cyc;
         f_bits[n_rise]   = bitcnt;
         f_word[n_rise]   = mosi_w;
         f_len[n_rise]    = cyc - fall_cyc[n_fall-1];
         f_idone[n_rise]  = idone;
         f_vld[n_rise]    = vld;
         n_rise++;
      end
      prev_ss   = ss_n;
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   // SS_n edge log for the short-period DUT
   int   cycf = 0, n_ffall = 0, n_frise = 0;
   int   ff_fall [64];
   int   ff_rise [64];
   logic prev_ssf = 1'b1;

   always @(negedge clk) begin
      cycf++;
      if (prev_ssf && !ss_f && n_ffall < 64) begin
         ff_fall[n_ffall] = cycf;
         n_ffall++;
      end
      if (!prev_ssf && ss_f && n_frise < 64) begin
         ff_rise[n_frise] = cycf;
         n_frise++;
      end
      prev_ssf = ss_f;
   end

   task automatic wait_rise(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && n_rise < n; i++) @(negedge clk);
      chk(tag, n_rise >= n, 1'b1);
   endtask

   task automatic wait_fall(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && n_fall < n; i++) @(negedge clk);
      chk(tag, n_fall >= n, 1'b1);
   endtask

   task automatic chk_sample(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                             input logic [15:0] ez, input logic [15:0] ec);
      chk({tag, "_x"}, ax, ex);
      chk({tag, "_y"}, ay, ey);
      chk({tag, "_z"}, az, ez);
      chk({tag, "_count"}, cnt, ec);
   endtask

   logic [15:0] init_w [3];
   int          k;

   initial begin
      init_w[0] = 16'h2C0A;
      init_w[1] = 16'h3108;
      init_w[2] = 16'h2D08;
      slv_data  = 48'h3412CDAB0180;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ss_n", ss_n, 1'b1);
      chk("rst_sclk", sclk, 1'b1);
      chk("rst_mosi", mosi, 1'b0);
      chk_sample("rst", 16'h0, 16'h0, 16'h0, 16'h0);
      chk("rst_valid", vld, 1'b0);
      chk("rst_init_done", idone, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // init must finish regardless of enable wiggling
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 600 && n_rise < 3; i++) begin
         @(negedge clk);
         en = i[2];
      end
      en = 1'b0;
      chk("init_three_frames", n_rise >= 3, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("init_bits", f_bits[i], 16);
         chk("init_word", f_word[i][15:0], init_w[i]);
         chk("init_len", f_len[i], 34 * CD);
         chk("init_done_at_rise", f_idone[i], (i == 2) ? 1'b1 : 1'b0);
      end
      chk("init_gap1", fall_cyc[1] - rise_cyc[0] >= 2 * CD, 1'b1);
      chk("init_gap2", fall_cyc[2] - rise_cyc[1] >= 2 * CD, 1'b1);
      chk("no_read_while_disabled_after_init", n_fall, 3);

      // first read
      en = 1'b1;
      wait_rise(4, 2600, "read1_done");
      slv_data = 48'hFF7F00005555;
      slv_data = 48'hFF7F000055AA;
      @(negedge clk); #1;
      chk("read1_bits", f_bits[3], 56);
      chk("read1_cmd", f_word[3], 56'hF2000000000000);
      chk("read1_len", f_len[3], 114 * CD);
      chk("read1_valid_at_rise", f_vld[3], 1'b1);
      chk("read1_valid_one_cycle", vld_cycles, 1);
      chk("read1_valid_low_after", vld, 1'b0);
      chk_sample("read1", 16'h1234, 16'hABCD, 16'h8001, 16'd1);

      // second read, one period after the first
      wait_rise(5, 2100, "read2_done");
      slv_data = 48'h0100FEFF0040;
      @(negedge clk); #1;
      chk("read_period", fall_cyc[4] - fall_cyc[3], SP);
      chk("read2_cmd", f_word[4], 56'hF2000000000000);
      chk("read2_valid_count", vld_cycles, 2);
      chk_sample("read2", 16'h7FFF, 16'h0000, 16'hAA55, 16'd2);

      // short period: back-to-back reads separated only by the minimum gap
      chk("fast_reads_seen", n_ffall >= 6, 1'b1);
      chk("fast_gap_a", ff_fall[4] - ff_rise[3], 2 * CD);
      chk("fast_gap_b", ff_fall[5] - ff_rise[4], 2 * CD);

      // enable dropped mid-read: frame still published, then silence
      wait_fall(6, 2100, "read3_start");
      repeat (50) @(negedge clk);
      en = 1'b0;
      wait_rise(6, 300, "read3_done");
      @(negedge clk); #1;
      chk("read3_bits", f_bits[5], 56);
      chk_sample("read3", 16'h0001, 16'hFFFE, 16'h4000, 16'd3);
      repeat (2500) @(negedge clk);
      chk("disabled_no_frames", n_fall, 6);
      chk("disabled_busy", busy, 1'b0);
      chk("disabled_ss_n", ss_n, 1'b1);
      en = 1'b1;
      wait_fall(7, 20, "reenable_read_start");

      // asynchronous reset in the middle of a read
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ss_n", ss_n, 1'b1);
      chk("arst_sclk", sclk, 1'b1);
      chk_sample("arst", 16'h0, 16'h0, 16'h0, 16'h0);
      chk("arst_init_done", idone, 1'b0);
      chk("arst_busy", busy, 1'b0);
      @(negedge clk);
      @(negedge clk);
      k = n_rise;
      rst_n = 1'b1;
      wait_rise(k + 1, 200, "reinit_frame");
      chk("reinit_bits", f_bits[k], 16);
      chk("reinit_word", f_word[k][15:0], 16'h2C0A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
